// File: rtl/pulpemu_clk_div_prog_if.sv
// Config request channel for the programmable clock divider.
// Master drives a request, slave answers with ready.
interface pulpemu_clk_div_prog_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = 16
) ();
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [CH_W-1:0]  cfg_ch_i;
  logic [CNT_W-1:0] cfg_div_i;
  logic             cfg_en_i;

  modport master (
    output cfg_valid_i, cfg_ch_i, cfg_div_i, cfg_en_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i, cfg_ch_i, cfg_div_i, cfg_en_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/pulpemu_clk_div_prog.sv
// Multi-channel programmable clock divider, glitch-free updates.
// PULPEMU_CLKDIV_ALIGN_EN adds align_i to re-phase all running channels.
module pulpemu_clk_div_prog #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 256,
  parameter int DEFAULT_EN  = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
`ifdef PULPEMU_CLKDIV_ALIGN_EN
  input  logic              align_i,
`endif
  pulpemu_clk_div_prog_if.slave cfg,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] running_o
);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_STOPPING
  } state_e;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam state_e ST_RST =
    (DEFAULT_EN != 0) ? ST_RUNNING : ST_STOPPED;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] div_q   [NUM_CH];
  logic [CNT_W-1:0] div_d   [NUM_CH];
  logic [CNT_W-1:0] pdiv_q  [NUM_CH];
  logic [CNT_W-1:0] pdiv_d  [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  logic             rdy;
  logic             ch_ok;
  logic [CNT_W-1:0] div_new;

  assign ch_ok = {1'b0, cfg.cfg_ch_i} < (CH_W+1)'(NUM_CH);
  assign div_new = (cfg.cfg_div_i < CNT_W'(2)) ?
                   CNT_W'(2) : cfg.cfg_div_i;

  always_comb begin
    rdy = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch_i == CH_W'(i) && pend_q[i]) rdy = 1'b0;
    end
  end

  assign cfg.cfg_ready_o = rdy;

  always_comb begin
    logic acc;
    logic wrap;
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = tick_q;
    acc     = 1'b0;
    wrap    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc  = cfg.cfg_valid_i && rdy && ch_ok &&
             (cfg.cfg_ch_i == CH_W'(i));
      wrap = cnt_q[i] == div_q[i] - 1'b1;
      unique case (state_q[i])
        ST_RUNNING, ST_STOPPING: begin
          cnt_d[i]  = wrap ? '0 : cnt_q[i] + 1'b1;
          clk_d[i]  = cnt_q[i] < (div_q[i] >> 1);
          tick_d[i] = cnt_q[i] == '0;
          if (wrap) begin
            if (pend_q[i]) begin
              div_d[i]  = pdiv_q[i];
              pend_d[i] = 1'b0;
            end
            if (state_q[i] == ST_STOPPING) state_d[i] = ST_STOPPED;
          end
        end
        default: begin
          cnt_d[i]  = '0;
          clk_d[i]  = 1'b0;
          tick_d[i] = 1'b0;
          if (acc) begin
            div_d[i] = div_new;
            if (cfg.cfg_en_i) state_d[i] = ST_RUNNING;
          end
        end
      endcase
`ifdef PULPEMU_CLKDIV_ALIGN_EN
      // align edge acts as a forced wrap: this cycle emits cnt==0
      if (align_i && state_q[i] != ST_STOPPED) begin
        if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          pend_d[i] = 1'b0;
        end
        if (state_q[i] == ST_RUNNING) begin
          cnt_d[i]  = CNT_W'(1);
          clk_d[i]  = 1'b1;
          tick_d[i] = 1'b1;
        end else begin
          state_d[i] = ST_STOPPED;
          cnt_d[i]   = '0;
          clk_d[i]   = 1'b0;
          tick_d[i]  = 1'b0;
        end
      end
`endif
      if (acc && state_q[i] != ST_STOPPED) begin
        pend_d[i] = 1'b1;
        pdiv_d[i] = div_new;
        if (!cfg.cfg_en_i) state_d[i] = ST_STOPPING;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_RST;
        cnt_q[i]   <= '0;
        div_q[i]   <= DIV_RST;
        pdiv_q[i]  <= DIV_RST;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        pdiv_q[i]  <= pdiv_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    running_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      running_o[i] = state_q[i] != ST_STOPPED;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule
